// File: rtl/rvh_noc_pkg.sv
// Shared width helpers and state encodings for the NoC input-port slice.
package rvh_noc_pkg;

   function automatic int vc_idx_w(input int vc_num);
      return (vc_num > 1) ? $clog2(vc_num) : 1;
   endfunction

   // Occupancy and pending-credit counters must hold the value DEPTH itself.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } init_state_e;

endpackage

// File: rtl/input_port_mq_if.sv
// Flit receive, credit return and SA-stage pop/head signals of one input port.
interface input_port_mq_if
   import rvh_noc_pkg::*;
#(
   parameter int FLIT_W   = 256,
   parameter int VC_NUM   = 4,
   parameter int VC_DEPTH = 4,
   parameter int VC_IDX_W = vc_idx_w(VC_NUM),
   parameter int CNT_W    = cnt_w(VC_DEPTH)
) ();

   logic                       rx_flit_v_i;
   logic [FLIT_W-1:0]          rx_flit_i;
   logic [VC_IDX_W-1:0]        rx_flit_vc_id_i;
   logic                       rx_lcrd_v_o;
   logic [VC_IDX_W-1:0]        rx_lcrd_id_o;
   logic [VC_NUM-1:0]          vc_head_vld_o;
   logic [VC_NUM*FLIT_W-1:0]   vc_head_data_o;
   logic                       pop_v_i;
   logic [VC_IDX_W-1:0]        pop_vc_id_i;
   logic [VC_NUM*CNT_W-1:0]    vc_occ_o;
   logic                       init_done_o;
   logic                       err_ovf_o;
   logic                       err_udf_o;

   modport slave (
      input  rx_flit_v_i, rx_flit_i, rx_flit_vc_id_i, pop_v_i, pop_vc_id_i,
      output rx_lcrd_v_o, rx_lcrd_id_o, vc_head_vld_o, vc_head_data_o,
             vc_occ_o, init_done_o, err_ovf_o, err_udf_o
   );

   modport master (
      output rx_flit_v_i, rx_flit_i, rx_flit_vc_id_i, pop_v_i, pop_vc_id_i,
      input  rx_lcrd_v_o, rx_lcrd_id_o, vc_head_vld_o, vc_head_data_o,
             vc_occ_o, init_done_o, err_ovf_o, err_udf_o
   );

endinterface

// File: rtl/input_port_mq_fifo.sv
// One virtual-channel circular FIFO; storage is unreset, pointers and count are.
module input_port_mq_fifo
   import rvh_noc_pkg::*;
#(
   parameter int FLIT_W = 256,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [FLIT_W-1:0] din,
   output logic [FLIT_W-1:0] head,
   output logic              vld,
   output logic [CNT_W-1:0]  cnt,
   output logic              push_acc,
   output logic              pop_acc
);

   localparam int PTR_W = ptr_w(DEPTH);

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rptr;
   logic [PTR_W-1:0]  wptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Fullness is judged on the pre-pop count, so a push to a full VC drops even alongside a pop.
   assign push_acc = push && (cnt != CNT_W'(DEPTH));
   assign pop_acc  = pop && (cnt != '0);
   assign vld      = (cnt != '0);
   assign head     = mem[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
      end else begin
         if (push_acc) wptr <= ptr_inc(wptr);
         if (pop_acc)  rptr <= ptr_inc(rptr);
         case ({push_acc, pop_acc})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) mem[wptr] <= din;
   end

endmodule

// File: rtl/input_port_mq.sv
// Multi-queue input port: per-VC FIFOs plus round-robin credit return.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | initial credits still owed to the sender
//   ST_RUN  | every pending counter has drained once; init_done_o high
module input_port_mq
   import rvh_noc_pkg::*;
#(
   parameter int FLIT_W   = 256,
   parameter int VC_NUM   = 4,
   parameter int VC_DEPTH = 4,
   parameter int VC_IDX_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
   input logic              clk,
   input logic              rst,
   input_port_mq_if.slave   mq
);

   localparam int CNT_W = cnt_w(VC_DEPTH);

   logic [VC_NUM-1:0]        push_req;
   logic [VC_NUM-1:0]        pop_req;
   logic [VC_NUM-1:0]        push_acc;
   logic [VC_NUM-1:0]        pop_acc;
   logic [VC_NUM-1:0]        head_vld;
   logic [VC_NUM-1:0]        elig;
   logic [VC_NUM-1:0]        dec;
   logic [VC_NUM*FLIT_W-1:0] head_data;
   logic [VC_NUM*CNT_W-1:0]  occ_flat;
   logic [CNT_W-1:0]         occ  [VC_NUM];
   logic [CNT_W-1:0]         pend [VC_NUM];

   logic                     gnt_v;
   logic [VC_IDX_W-1:0]      gnt_id;
   logic [VC_IDX_W-1:0]      rr_ptr;
   logic                     lcrd_v;
   logic [VC_IDX_W-1:0]      lcrd_id;
   logic                     err_ovf;
   logic                     err_udf;
   init_state_e              state_q;
   init_state_e              state_d;
   logic                     init_done;

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      assign push_req[v] = mq.rx_flit_v_i && (mq.rx_flit_vc_id_i == VC_IDX_W'(v));
      assign pop_req[v]  = mq.pop_v_i && (mq.pop_vc_id_i == VC_IDX_W'(v));

      input_port_mq_fifo #(
         .FLIT_W (FLIT_W),
         .DEPTH  (VC_DEPTH),
         .CNT_W  (CNT_W)
      ) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .push     (push_req[v]),
         .pop      (pop_req[v]),
         .din      (mq.rx_flit_i),
         .head     (head_data[v*FLIT_W +: FLIT_W]),
         .vld      (head_vld[v]),
         .cnt      (occ[v]),
         .push_acc (push_acc[v]),
         .pop_acc  (pop_acc[v])
      );

      assign occ_flat[v*CNT_W +: CNT_W] = occ[v];
      assign elig[v] = (pend[v] != '0);
      assign dec[v]  = gnt_v && (gnt_id == VC_IDX_W'(v));

      // Pending credits start at full depth so the sender learns the buffer size after reset.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            pend[v] <= CNT_W'(VC_DEPTH);
         end else begin
            case ({pop_acc[v], dec[v]})
               2'b10:   pend[v] <= pend[v] + 1'b1;
               2'b01:   pend[v] <= pend[v] - 1'b1;
               default: pend[v] <= pend[v];
            endcase
         end
      end

      a_pend_max: assert property (@(posedge clk) disable iff (rst)
         pend[v] <= CNT_W'(VC_DEPTH));
      a_pend_occ: assert property (@(posedge clk) disable iff (rst)
         ({1'b0, pend[v]} + {1'b0, occ[v]}) <= (CNT_W + 1)'(VC_DEPTH));
   end

   always_comb begin
      gnt_v  = 1'b0;
      gnt_id = '0;
      for (int i = 0; i < VC_NUM; i++) begin
         if (!gnt_v && elig[(int'(rr_ptr) + i) % VC_NUM]) begin
            gnt_v  = 1'b1;
            gnt_id = VC_IDX_W'((int'(rr_ptr) + i) % VC_NUM);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr  <= '0;
         lcrd_v  <= 1'b0;
         lcrd_id <= '0;
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else begin
         lcrd_v  <= gnt_v;
         lcrd_id <= gnt_id;
         if (gnt_v) begin
            rr_ptr <= (gnt_id == VC_IDX_W'(VC_NUM - 1)) ? '0 : gnt_id + 1'b1;
         end
         err_ovf <= err_ovf | (|(push_req & ~push_acc));
         err_udf <= err_udf | (|(pop_req & ~pop_acc));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_INIT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      init_done = 1'b0;
      case (state_q)
         ST_INIT: if (elig == '0) state_d = ST_RUN;
         ST_RUN:  init_done = 1'b1;
         default: state_d = ST_INIT;
      endcase
   end

   assign mq.rx_lcrd_v_o    = lcrd_v;
   assign mq.rx_lcrd_id_o   = lcrd_id;
   assign mq.vc_head_vld_o  = head_vld;
   assign mq.vc_head_data_o = head_data;
   assign mq.vc_occ_o       = occ_flat;
   assign mq.init_done_o    = init_done;
   assign mq.err_ovf_o      = err_ovf;
   assign mq.err_udf_o      = err_udf;

endmodule

// File: doc/input_port_mq.md
INPUT_PORT_MQ -- requirements
Module: input_port_mq

Interface
REQ-001 SHALL have parameter FLIT_W, default 256: flit payload width in bits.
REQ-002 SHALL have parameter VC_NUM, default 4: number of virtual channels (1..8).
REQ-003 SHALL have parameter VC_DEPTH, default 4: flit slots per VC (1..16).
REQ-004 SHALL have parameter VC_IDX_W, default VC_NUM>1 ? clog2(VC_NUM) : 1: VC index width.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port rx_flit_v_i, input, 1: incoming flit valid.
REQ-008 SHALL have port rx_flit_i, input, FLIT_W: incoming flit payload.
REQ-009 SHALL have port rx_flit_vc_id_i, input, VC_IDX_W: target VC of the incoming flit.
REQ-010 SHALL have port rx_lcrd_v_o, output, 1: credit return valid to the sender.
REQ-011 SHALL have port rx_lcrd_id_o, output, VC_IDX_W: VC of the returned credit.
REQ-012 SHALL have port vc_head_vld_o, output, VC_NUM: per-VC head valid, meaning the VC is non-empty.
REQ-013 SHALL have port vc_head_data_o, output, VC_NUM*FLIT_W: per-VC head flit, with VC v in bits [v*FLIT_W +: FLIT_W].
REQ-014 SHALL have port pop_v_i, input, 1: pop request from the SA stage.
REQ-015 SHALL have port pop_vc_id_i, input, VC_IDX_W: VC to pop.
REQ-016 SHALL have port vc_occ_o, output, VC_NUM*clog2(VC_DEPTH+1): per-VC occupancy count.
REQ-017 SHALL have port init_done_o, output, 1: all initial credits have been issued.
REQ-018 SHALL have port err_ovf_o, output, 1: sticky flag, a push was made to a full VC.
REQ-019 SHALL have port err_udf_o, output, 1: sticky flag, a pop was made from an empty VC.

Function
REQ-020 Each VC SHALL be an independent circular FIFO with its own read pointer, write pointer and count, each wrapping modulo VC_DEPTH.
REQ-021 A push (rx_flit_v_i=1) to a VC whose count is below VC_DEPTH SHALL be written at the rising edge, with the updated head, valid and occupancy visible in the next cycle (1-cycle latency, no bypass).
REQ-022 A push to a full VC SHALL be dropped and SHALL set err_ovf_o, even when the same VC is popped in the same cycle.
REQ-023 A pop to a non-empty VC SHALL advance that VC's read pointer and decrement its count.
REQ-024 A pop to an empty VC SHALL have no effect on any FIFO state, SHALL set err_udf_o, and SHALL NOT generate a credit.
REQ-025 A push and a pop to the same non-full, non-empty VC in the same cycle SHALL leave the count unchanged and SHALL preserve flit order.
REQ-026 A push and a pop to different VCs in the same cycle SHALL both take effect.
REQ-027 Each VC SHALL have a pending-credit counter of width clog2(VC_DEPTH+1), reset to VC_DEPTH.
REQ-028 Each accepted pop SHALL increment the pending-credit counter of the popped VC.
REQ-029 Each issued credit SHALL decrement the pending-credit counter of its VC; an increment and a decrement of the same counter in one cycle SHALL leave it unchanged.
REQ-030 At most one credit SHALL be issued per cycle, chosen round-robin among VCs whose pending count is non-zero.
REQ-031 The round-robin pointer SHALL reset to 0, SHALL select the lowest-index eligible VC at or above the pointer (wrapping), and SHALL move to the granted index + 1 (mod VC_NUM) after each grant.
REQ-032 rx_lcrd_v_o and rx_lcrd_id_o SHALL be registered outputs, so a pop in cycle N yields its credit no earlier than cycle N+1.
REQ-033 init_done_o SHALL rise in the cycle after all pending counters first reach 0 together, and SHALL then stay high until reset.
REQ-034 Pops that occur during initialisation SHALL be queued in the pending counters and returned by the same round-robin arbitration; no credit SHALL be lost or duplicated.
REQ-035 A pending-credit counter SHALL never exceed VC_DEPTH, and the sum of pending credits and count for any VC SHALL be at most VC_DEPTH (assertion-checked).

Reset
REQ-036 While rst=1, all FIFO counts and pointers, the round-robin pointer, rx_lcrd_v_o, rx_lcrd_id_o, vc_head_vld_o, vc_occ_o, init_done_o, err_ovf_o and err_udf_o SHALL be 0.
REQ-037 While rst=1, every pending-credit counter SHALL be VC_DEPTH.
REQ-038 FIFO storage SHALL need no reset, and vc_head_data_o SHALL be don't-care while the matching vc_head_vld_o is 0.
REQ-039 Reset asserted mid-operation SHALL discard all buffered flits and restart the initial credit sequence.

Structure
REQ-040 Width helpers and the credit/occupancy count widths SHALL be in rvh_noc_pkg.
REQ-041 The per-VC FIFO SHALL be sub-module input_port_mq_fifo, instantiated VC_NUM times.
REQ-042 The credit arbiter SHALL be inline in input_port_mq.

Verification (VC_NUM=4, VC_DEPTH=4)
REQ-043 Release reset with no traffic -> 16 credits on consecutive cycles with ids 0,1,2,3 repeated, then init_done_o=1 one cycle later.
REQ-044 After init, push 4 flits A..D into VC2, then pop VC2 four times -> heads A,B,C,D in order, vc_occ for VC2 goes 4,3,2,1,0, and 4 credits with id 2.
REQ-045 Fill VC1 to 4 flits, then push a fifth flit together with a pop of VC1 -> fifth flit dropped, err_ovf_o=1, occupancy 3.
REQ-046 Pop empty VC3 -> err_udf_o=1, no credit, all occupancies unchanged.
REQ-047 Pop VC0 and VC3 on cycles 2 and 3 of initialisation -> exactly 18 credits in total, with VC0 and VC3 each receiving 5.
REQ-048 Assert rst while VC0 holds 2 flits and credits are pending -> all outputs 0, then a fresh 16-credit sequence after release.
